// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Brief    : PC register and single-outstanding instruction fetch / issue FSM.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch #(
  parameter int PCW = 6,
  parameter int IW  = 8,
  parameter int CW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_data,
  output logic [IW-1:0]  instr,
  output logic           instr_valid,
  input  logic           exec_done,
  input  logic           pcSel,
  input  logic [PCW-1:0] alu_out,
  output logic [PCW-1:0] pc,
  output logic [CW-1:0]  retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  localparam logic [PCW-1:0] c_pc_one  = PCW'(1);
  localparam logic [CW-1:0]  c_ret_one = CW'(1);

  state_t         r_state;
  logic [PCW-1:0] r_pc;
  logic [IW-1:0]  r_instr;
  logic [CW-1:0]  r_retired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          // Run is deliberately not sampled: an outstanding fetch must complete.
          if (imem_ack) begin
            r_instr <= imem_data;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (exec_done) begin
            // Sums are truncated to PCW bits so branches wrap in both directions.
            r_pc      <= pcSel ? (r_pc + c_pc_one) : (r_pc + alu_out);
            r_retired <= r_retired + c_ret_one;
            r_state   <= run ? S_FETCH : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_ISSUE);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign retired     = r_retired;

endmodule
`default_nettype wire

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage for the McCoy core. It holds the PC, fetches one instruction at a time from the external instruction store over a req/ack handshake, presents it to the execute stage, and on execute completion advances the PC. The next PC is PC + 1 or PC + ALU output, chosen by the `pcSel` signal from the branch stage. The block sits directly downstream of the branch logic and upstream of decode/execute.

## Interface
- `PCW`, 6: PC / address width; also the width of the ALU offset.
- `IW`, 8: instruction width.
- `CW`, 8: retired-instruction counter width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; allows fetching to begin or continue.
- `imem_req`  out  1  fetch request to the instruction store.
- `imem_addr`  out  PCW  fetch address; always equals `pc`.
- `imem_ack`  in  1  the store has data valid on `imem_data` this cycle.
- `imem_data`  in  IW  instruction from the store.
- `instr`  out  IW  latched instruction.
- `instr_valid`  out  1  `instr` is valid and awaiting execution.
- `exec_done`  in  1  execute stage has finished the current instruction.
- `pcSel`  in  1  from the branch stage: 1 selects PC + 1, 0 selects PC + `alu_out`.
- `alu_out`  in  PCW  branch/jump offset, two's complement.
- `pc`  out  PCW  current PC.
- `retired`  out  CW  count of completed instructions.

## Operation
- FSM states:
  - IDLE (encoding 0)
  - FETCH
  - ISSUE
- Outputs derived from state:
  - `imem_req` = (state == FETCH)
  - `instr_valid` = (state == ISSUE)
- IDLE:
  - `run` = 1 → FETCH.
  - Otherwise stay in IDLE.
  - `imem_ack` and `exec_done` are ignored.
- FETCH:
  - `imem_ack` = 1 → `instr` <= `imem_data`, go to ISSUE.
  - Otherwise stay in FETCH, holding `imem_req` high and `imem_addr` stable.
  - `run` is not sampled here; an outstanding fetch always completes.
  - `exec_done` is ignored.
- ISSUE:
  - `exec_done` = 1 → update the PC, `retired` <= `retired` + 1, then:
    - `run` = 1 → FETCH
    - `run` = 0 → IDLE
  - Otherwise stay in ISSUE with `instr` held.
  - `imem_ack` is ignored.
- Next-PC rule, applied at the `exec_done` edge:
  - `pcSel` = 1 → `pc` + 1.
  - `pcSel` = 0 → `pc` + `alu_out`.
  - All arithmetic is modulo 2^PCW (no carry out), so both forward and backward branches wrap.
- `retired` wraps from 2^CW−1 to 0 and carries no saturation flag.
- `instr` changes only on an accepted ack; `pc` changes only on an accepted `exec_done`.
- Reset (asynchronous, any state, including mid-fetch or mid-issue):
  - state = IDLE, `pc` = 0, `instr` = 0, `retired` = 0.
  - `imem_req` = 0 and `instr_valid` = 0 immediately, with no clock edge required.
  - After reset, the branch stage forces `pcSel` = 1; this block adds no special handling for it.

## Timing
- All outputs are registered or decoded directly from registered state.
- No combinational path from any input to any output.
- From reset deassert with `run` = 1:
  - First edge: IDLE → FETCH.
  - `imem_req` is high in the following cycle.
- Ack latency is unbounded. An ack in the first FETCH cycle is accepted, and `instr_valid` rises in the next cycle.
- `exec_done` in the first ISSUE cycle is accepted.
- Minimum throughput is 2 cycles per instruction (one FETCH, one ISSUE).
- `pc`, `imem_addr`, and `retired` update at the same edge that leaves ISSUE. The new address is presented together with `imem_req` in the next cycle.

## Test plan
- Reset then `run` = 1, store acks immediately with 0x11, 0x22, …; `exec_done` pulsed in each ISSUE cycle, `pcSel` = 1:
  - `imem_addr` sequence 0, 1, 2, 3.
  - `instr_valid` toggles every other cycle.
  - `retired` = 4 after 4 completions.
- `pc` = 10, `pcSel` = 0, `alu_out` = 6'h3C (−4) → next `pc` = 6.
- `pc` = 62, `pcSel` = 0, `alu_out` = 5 → `pc` = 3 (wrap).
- `pc` = 63, `pcSel` = 1 → `pc` = 0.
- Ack held low for 5 cycles:
  - `imem_req` stays high with a stable address.
  - `exec_done` pulses during FETCH do not change `pc` or `retired`.
  - On ack, data is latched and `instr_valid` rises in the next cycle.
- `run` dropped during FETCH: the fetch completes, ISSUE is entered, and on `exec_done` the FSM goes to IDLE with `pc` advanced. `imem_req` remains 0 until `run` returns.
- `reset` pulsed mid-ISSUE, with no clock edge:
  - `instr_valid` = 0, `pc` = 0, `retired` = 0 immediately.
  - After deassert, fetch restarts at address 0.
